// File: rtl/aria_round_ctrl.sv
// ---------------------------------------------------------------------------
// aria_round_ctrl
//
// Round controller for the ARIA 1.1 core. It sequences round-key expansion
// and block encryption/decryption. It drives the round-key address
// generator (rk_op/rk_en/rk_clr/st_ksize/flg_dec) and the per-round strobes
// of the round datapath. It also owns the start/done handshakes toward the
// host interface.
//
// Ports
//   clk, rst_n     clock; asynchronous active-low reset
//   ksize_i        key size, sampled on key_start (01=128, 10=192, 11=256)
//   key_start      request key expansion (single-cycle pulse)
//   blk_start      request one block operation (single-cycle pulse)
//   dec_i          direction, sampled on blk_start (1=decrypt)
//   abort          synchronous abort of the operation in progress
//   rk_op, rk_en   address-generator opcode and update enable
//   rk_clr         address-generator clear (one cycle after an abort)
//   st_ksize       latched key size
//   flg_dec        latched direction
//   ks_we          key-schedule round-key write enable
//   rnd_en         datapath round enable
//   rnd_first      first round of a block
//   rnd_last       last full round of a block
//   rnd_fin        final whitening-key XOR cycle
//   busy           controller not idle
//   key_rdy        a valid expanded key is held
//   kx_done        one-cycle pulse at the end of key expansion
//   blk_done       one-cycle pulse at the end of a block
//   err            one-cycle pulse on a rejected request
//
// Build option
//   ARIA_CTRL_BACK2BACK_EN: when defined, a blk_start that arrives during the
//   final whitening cycle starts the next block directly. This removes the
//   idle cycle between blocks.
// ---------------------------------------------------------------------------
module aria_round_ctrl #(
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ksize_i,
    input  logic       key_start,
    input  logic       blk_start,
    input  logic       dec_i,
    input  logic       abort,
    output logic [1:0] rk_op,
    output logic       rk_en,
    output logic       rk_clr,
    output logic [1:0] st_ksize,
    output logic       flg_dec,
    output logic       ks_we,
    output logic       rnd_en,
    output logic       rnd_first,
    output logic       rnd_last,
    output logic       rnd_fin,
    output logic       busy,
    output logic       key_rdy,
    output logic       kx_done,
    output logic       blk_done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KX_LOAD,
        S_KX_RUN,
        S_R_LOAD,
        S_R_RUN,
        S_R_FINAL
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_ksize;
    logic             r_dec;
    logic             r_keyRdy;
    logic             r_kxDone;
    logic             r_blkDone;
    logic             r_err;
    logic             r_rkClr;
    logic [CNT_W-1:0] w_lastRnd;
    logic             w_b2bTake;

    // Select the round count N for the latched key size. The round counter
    // is compared against N exactly, so it stays at or below 16. A latched
    // key size of 00 cannot occur while the controller is busy.
    always_comb begin
        case (r_ksize)
            2'b10:   w_lastRnd = CNT_W'(14);
            2'b11:   w_lastRnd = CNT_W'(16);
            default: w_lastRnd = CNT_W'(12);
        endcase
    end

    // In the back-to-back build, a new block may start from the final
    // whitening cycle. In the default build, that request is ignored in the
    // same way as any other request made while busy.
`ifdef ARIA_CTRL_BACK2BACK_EN
    assign w_b2bTake = blk_start & r_keyRdy;
`else
    assign w_b2bTake = 1'b0;
`endif

    // Main sequencer: state, round counter, latched configuration and the
    // registered pulses (kx_done, blk_done, err, rk_clr).
    // The pulses default low every cycle.
    // Abort takes priority over every transition in a non-idle state.
    // An abort leaves key_rdy unchanged: key_rdy is already 0 during key
    // expansion and stays 1 during a block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ksize   <= 2'b00;
            r_dec     <= 1'b0;
            r_keyRdy  <= 1'b0;
            r_kxDone  <= 1'b0;
            r_blkDone <= 1'b0;
            r_err     <= 1'b0;
            r_rkClr   <= 1'b0;
        end else begin
            r_kxDone  <= 1'b0;
            r_blkDone <= 1'b0;
            r_err     <= 1'b0;
            r_rkClr   <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                r_rkClr <= 1'b1;
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (key_start) begin
                            if (ksize_i != 2'b00) begin
                                r_ksize  <= ksize_i;
                                r_keyRdy <= 1'b0;
                                r_state  <= S_KX_LOAD;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else if (blk_start) begin
                            if (r_keyRdy) begin
                                r_dec   <= dec_i;
                                r_state <= S_R_LOAD;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_KX_LOAD: begin
                        r_cnt   <= '0;
                        r_state <= S_KX_RUN;
                    end
                    S_KX_RUN: begin
                        if (r_cnt == w_lastRnd) begin
                            r_keyRdy <= 1'b1;
                            r_kxDone <= 1'b1;
                            r_cnt    <= '0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_R_LOAD: begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= S_R_RUN;
                    end
                    S_R_RUN: begin
                        if (r_cnt == w_lastRnd) begin
                            r_cnt   <= '0;
                            r_state <= S_R_FINAL;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_R_FINAL: begin
                        r_blkDone <= 1'b1;
                        if (w_b2bTake) begin
                            r_dec   <= dec_i;
                            r_state <= S_R_LOAD;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Moore decode of the address-generator and datapath strobes from the
    // current state and round counter.
    always_comb begin
        rk_op     = 2'b00;
        rk_en     = 1'b0;
        ks_we     = 1'b0;
        rnd_en    = 1'b0;
        rnd_first = 1'b0;
        rnd_last  = 1'b0;
        rnd_fin   = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_KX_LOAD: begin
                rk_op = 2'b00;
                rk_en = 1'b1;
            end
            S_KX_RUN: begin
                rk_op = 2'b01;
                ks_we = 1'b1;
                rk_en = (r_cnt != w_lastRnd);
            end
            S_R_LOAD: begin
                rk_op = 2'b10;
                rk_en = 1'b1;
            end
            S_R_RUN: begin
                rk_op     = 2'b11;
                rk_en     = 1'b1;
                rnd_en    = 1'b1;
                rnd_first = (r_cnt == CNT_W'(1));
                rnd_last  = (r_cnt == w_lastRnd);
            end
            S_R_FINAL: begin
                rnd_fin = 1'b1;
            end
            default: begin
                rk_op = 2'b00;
            end
        endcase
    end

    assign st_ksize = r_ksize;
    assign flg_dec  = r_dec;
    assign key_rdy  = r_keyRdy;
    assign kx_done  = r_kxDone;
    assign blk_done = r_blkDone;
    assign err      = r_err;
    assign rk_clr   = r_rkClr;

endmodule

// File: tb/tb_aria_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aria_round_ctrl
//
// Self-checking bench for aria_round_ctrl.
//
// The reference model works from operation timelines. A key expansion or a
// block started at cycle T is described as the output pattern expected in
// each cycle T+k, computed from the round count N = 10 + 2*ksize. The model
// also keeps the latched key size, the direction and the key-ready flag.
//
// Inputs are driven on the falling edge, and all outputs are compared as
// one packed vector on the falling edge.
//
// Build option: ARIA_CTRL_BACK2BACK_EN selects the expected behaviour for a
// blk_start that arrives during the final whitening cycle.
// ---------------------------------------------------------------------------
module tb_aria_round_ctrl;

`ifdef ARIA_CTRL_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] ksize_i;
    logic       key_start;
    logic       blk_start;
    logic       dec_i;
    logic       abort;
    logic [1:0] rk_op;
    logic       rk_en, rk_clr, flg_dec, ks_we, rnd_en, rnd_first, rnd_last;
    logic       rnd_fin, busy, key_rdy, kx_done, blk_done, err;
    logic [1:0] st_ksize;
    logic [16:0] obs;

    int checks   = 0;
    int failures = 0;

    bit         mKeyRdy = 1'b0;
    logic [1:0] mKs     = 2'b00;
    bit         mDec    = 1'b0;

    always #5 clk = ~clk;

    aria_round_ctrl #(.CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ksize_i   (ksize_i),
        .key_start (key_start),
        .blk_start (blk_start),
        .dec_i     (dec_i),
        .abort     (abort),
        .rk_op     (rk_op),
        .rk_en     (rk_en),
        .rk_clr    (rk_clr),
        .st_ksize  (st_ksize),
        .flg_dec   (flg_dec),
        .ks_we     (ks_we),
        .rnd_en    (rnd_en),
        .rnd_first (rnd_first),
        .rnd_last  (rnd_last),
        .rnd_fin   (rnd_fin),
        .busy      (busy),
        .key_rdy   (key_rdy),
        .kx_done   (kx_done),
        .blk_done  (blk_done),
        .err       (err)
    );

    // All outputs are packed into one vector, so a single comparison covers
    // the whole interface.
    assign obs = {rk_op, rk_en, rk_clr, ks_we, rnd_en, rnd_first, rnd_last,
                  rnd_fin, busy, key_rdy, kx_done, blk_done, err, st_ksize, flg_dec};

    function automatic int rounds(input logic [1:0] ks);
        return 10 + 2 * int'(ks);
    endfunction

    function automatic logic [16:0] vec(input logic [1:0] op, input bit en, input bit clr,
                                        input bit kswe, input bit rnden, input bit rfirst,
                                        input bit rlast, input bit rfin, input bit bsy,
                                        input bit kxd, input bit bd, input bit er);
        return {op, en, clr, kswe, rnden, rfirst, rlast, rfin, bsy,
                mKeyRdy, kxd, bd, er, mKs, mDec};
    endfunction

    function automatic logic [16:0] idleVec(input bit kxd, input bit bd, input bit er, input bit clr);
        return vec(2'b00, 1'b0, clr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, kxd, bd, er);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] ks, input logic kst, input logic bst,
                                 input logic dc, input logic ab);
        ksize_i   = ks;
        key_start = kst;
        blk_start = bst;
        dec_i     = dc;
        abort     = ab;
    endtask

    task automatic checkOutput(input string tag, input int cyc, input logic [16:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    // Key expansion: start at the current cycle, optionally collide with
    // blk_start, optionally abort at cycle T+abortAt, optionally drive
    // ignored requests while busy.
    task automatic doKx(input logic [1:0] ks, input bit withBlk, input int abortAt, input bit noise);
        int n;
        logic [16:0] e;
        applyStimulus(ks, 1'b1, withBlk, 1'($urandom), 1'b0);
        if (ks == 2'b00) begin
            step();
            applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("kx_badsize_err", 1, idleVec(1'b0, 1'b0, 1'b1, 1'b0));
            step();
            checkOutput("kx_badsize_idle", 2, idleVec(1'b0, 1'b0, 1'b0, 1'b0));
            return;
        end
        n = rounds(ks);
        mKs = ks;
        mKeyRdy = 1'b0;
        for (int k = 1; k <= n + 2; k++) begin
            step();
            applyStimulus(2'($urandom), noise && ($urandom % 4 == 0),
                          noise && ($urandom % 4 == 0), 1'($urandom), 1'b0);
            if (k == 1)
                e = vec(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            else
                e = vec(2'b01, (k - 2) != n, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                        1'b0, 1'b0, 1'b0);
            checkOutput("kx_run", k, e);
            if (k == abortAt) begin
                applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
                step();
                applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
                checkOutput("kx_abort_clr", k + 1, idleVec(1'b0, 1'b0, 1'b0, 1'b1));
                step();
                checkOutput("kx_abort_idle", k + 2, idleVec(1'b0, 1'b0, 1'b0, 1'b0));
                return;
            end
        end
        step();
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        mKeyRdy = 1'b1;
        checkOutput("kx_done", n + 3, idleVec(1'b1, 1'b0, 1'b0, 1'b0));
        step();
        checkOutput("kx_idle", n + 4, idleVec(1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // Block operation: optionally abort at cycle T+abortAt of the first
    // block, and optionally request 'chain' further blocks, each during the
    // final whitening cycle of the previous block.
    task automatic doBlk(input bit dec, input int abortAt, input int chain, input bit noise);
        int n;
        bit pend;
        logic [16:0] e;
        applyStimulus(2'($urandom), 1'b0, 1'b1, dec, 1'b0);
        if (!mKeyRdy) begin
            step();
            applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("blk_nokey_err", 1, idleVec(1'b0, 1'b0, 1'b1, 1'b0));
            step();
            checkOutput("blk_nokey_idle", 2, idleVec(1'b0, 1'b0, 1'b0, 1'b0));
            return;
        end
        n = rounds(mKs);
        pend = dec;
        for (int b = 0; b <= chain; b++) begin
            for (int k = 1; k <= n + 2; k++) begin
                step();
                applyStimulus(2'($urandom), noise && ($urandom % 4 == 0),
                              noise && (k <= n + 1) && ($urandom % 4 == 0), 1'($urandom), 1'b0);
                if (k == 1) begin
                    mDec = pend;
                    e = vec(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                            1'b0, b > 0, 1'b0);
                end else if (k <= n + 1) begin
                    e = vec(2'b11, 1'b1, 1'b0, 1'b0, 1'b1, (k - 1) == 1, (k - 1) == n, 1'b0,
                            1'b1, 1'b0, 1'b0, 1'b0);
                end else begin
                    e = vec(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                            1'b0, 1'b0, 1'b0);
                end
                checkOutput("blk_run", k, e);
                if (b == 0 && k == abortAt) begin
                    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
                    step();
                    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
                    checkOutput("blk_abort_clr", k + 1, idleVec(1'b0, 1'b0, 1'b0, 1'b1));
                    step();
                    checkOutput("blk_abort_idle", k + 2, idleVec(1'b0, 1'b0, 1'b0, 1'b0));
                    return;
                end
                if (k == n + 2 && b < chain) begin
                    pend = 1'($urandom);
                    applyStimulus(2'($urandom), 1'b0, 1'b1, pend, 1'b0);
                end
            end
            if (b < chain && !B2B) break;
        end
        step();
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("blk_done", n + 3, idleVec(1'b0, 1'b1, 1'b0, 1'b0));
        step();
        checkOutput("blk_idle", n + 4, idleVec(1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // Directed steps follow the test plan, followed by a randomized run
    // against the timeline model.
    initial begin
        int sel;
        int ab;
        logic [1:0] ks;
        rst_n = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        checkOutput("reset_state", 0, idleVec(1'b0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;
        step();
        checkOutput("reset_release", 0, idleVec(1'b0, 1'b0, 1'b0, 1'b0));

        doBlk(1'b1, 0, 0, 1'b0);
        doKx(2'b00, 1'b0, 0, 1'b0);
        doKx(2'b01, 1'b0, 0, 1'b0);
        doKx(2'b00, 1'b0, 0, 1'b0);
        doKx(2'b11, 1'b0, 0, 1'b0);
        doBlk(1'b1, 0, 0, 1'b0);
        doKx(2'b10, 1'b1, 0, 1'b0);
        doBlk(1'b0, 6, 0, 1'b0);

        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_in_idle", 1, idleVec(1'b0, 1'b0, 1'b0, 1'b0));

        doKx(2'b01, 1'b0, 5, 1'b0);
        doBlk(1'b0, 0, 0, 1'b0);
        doKx(2'b01, 1'b0, 0, 1'b0);
        doBlk(1'b0, 0, 2, 1'b0);

        // Asynchronous reset in the middle of a block.
        doKx(2'b10, 1'b0, 0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        #2 rst_n = 1'b0;
        #1;
        mKeyRdy = 1'b0;
        mKs = 2'b00;
        mDec = 1'b0;
        checkOutput("async_reset", 0, idleVec(1'b0, 1'b0, 1'b0, 1'b0));
        step();
        rst_n = 1'b1;
        checkOutput("async_reset_hold", 1, idleVec(1'b0, 1'b0, 1'b0, 1'b0));
        step();

        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3 || !mKeyRdy) begin
                ks = 2'($urandom);
                ab = ($urandom % 4 == 0) ? $urandom_range(1, rounds(ks) + 2) : 0;
                doKx(ks, 1'($urandom), ab, 1'b1);
            end else begin
                ab = ($urandom % 5 == 0) ? $urandom_range(1, rounds(mKs) + 2) : 0;
                doBlk(1'($urandom), ab, $urandom_range(0, 2), 1'b1);
            end
            repeat ($urandom_range(0, 2)) begin
                step();
                checkOutput("idle_gap", 0, idleVec(1'b0, 1'b0, 1'b0, 1'b0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
